twiddle_addr_seq: RTL and testbench
===================================

Name: twiddle_addr_seq

Overview:
- Upstream sequencer for the 4-ROM twiddle reader used by the recover-2N-point FFT stage.
- Per frame, issues paired mirrored addresses (k on col1, LEN-1-k on col2) together with the ROM read valid.
- Generates a latency-matched twiddle-valid/last strobe, aligned to the reader's registered outputs, for the downstream butterfly.
- Supports a start/busy/done handshake and downstream back-pressure.

Parameters:
- ADDR_W, 11, ROM address width; must match the reader's addr_col1/addr_col2 width.
- ROM_LAT, 1, read latency of the twiddle reader in cycles (valid/addr in to data out), range 1..4.
- MAX_LEN, 2048, largest legal frame length in address steps (2**ADDR_W).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active-high (1 = reset), sampled on clk.
- start_i  in  1  one-cycle request to begin a frame; ignored unless idle.
- len_i  in  ADDR_W+1  frame length in address steps, latched on accepted start; legal 1..MAX_LEN.
- ready_i  in  1  downstream can accept new twiddle sets; low stalls address issue.
- rom_valid_o  out  1  read strobe to the reader's valid input.
- addr_col1_o  out  ADDR_W  forward address k.
- addr_col2_o  out  ADDR_W  mirrored address LEN-1-k.
- tw_valid_o  out  1  reader outputs (data_o_col1/col2[3:0]) are valid this cycle.
- tw_last_o  out  1  qualifies the final twiddle set of the frame; only high with tw_valid_o.
- busy_o  out  1  frame in progress (RUN or DRAIN).
- done_o  out  1  one-cycle pulse after the last twiddle set is delivered.
- err_len_o  out  1  one-cycle pulse when start is rejected for an illegal length.

Behaviour:
- Reset:
  - All outputs are 0; addresses are 0; FSM is IDLE; shift pipes are cleared.
  - Reset mid-frame aborts immediately: no done, and no tw_valid_o on the next cycle.
- FSM states:
  - IDLE: start_i with len_i in 1..MAX_LEN → latch len, k=0, go to RUN. Illegal len (0 or >MAX_LEN) → err_len_o pulse, stay IDLE.
  - RUN: each cycle with ready_i=1: rom_valid_o=1, addr_col1_o=k, addr_col2_o=len-1-k, k++. Issuing k=len-1 → go to DRAIN.
  - RUN, ready_i=0: rom_valid_o=0, addresses hold their last values, k holds.
  - DRAIN: wait until the last issued read emerges (ROM_LAT cycles), then go to DONE.
  - DONE: done_o=1 for one cycle, then go to IDLE.
- Output timing:
  - Address and rom_valid_o are registered outputs. First issue occurs the cycle after start is accepted.
  - tw_valid_o equals rom_valid_o delayed by exactly ROM_LAT cycles via a shift pipe.
  - tw_last_o equals the "issuing k=len-1" flag delayed by the same ROM_LAT-cycle pipe.
- Back-pressure: ready_i gates issue only. Reads already in flight (at most ROM_LAT) still emerge, so the consumer must absorb ROM_LAT sets after dropping ready_i.
- Arithmetic:
  - k is an ADDR_W+1-bit counter.
  - Mirror address is computed as len-1-k in ADDR_W+1 bits and truncated to ADDR_W; it never underflows because k ≤ len-1.
  - len=MAX_LEN covers the full ROM range 0..2**ADDR_W-1.
- Boundaries:
  - len=1: one issue with col1=col2=0, last flagged on that set.
  - start_i while busy: ignored, latched len unchanged.
  - start_i and done_o in the same cycle: start is ignored (not idle); it is accepted from the following IDLE cycle.
  - ready_i toggling every cycle: no address is skipped or duplicated.
- busy_o is high in RUN and DRAIN; low in IDLE and DONE.

Test Plan:
- Basic frame: reset, start with len=4, ready=1.
  - rom_valid 4 cycles; col1=0,1,2,3 and col2=3,2,1,0.
  - tw_valid follows 1 cycle later (ROM_LAT=1), tw_last on the 4th set.
  - done pulse 1 cycle after tw_last; busy falls together with done.
- Stall: len=8, ready low for 3 cycles after the 2nd issue.
  - Addresses hold at col1=1/col2=6 with rom_valid=0.
  - Issue resumes at col1=2; exactly 8 tw_valid total.
- Edge lengths:
  - len=1 → a single set, col1=col2=0, tw_valid and tw_last together.
  - len=2048 → last set col1=2047/col2=0; err_len stays 0.
- Illegal length:
  - start with len=0 → err_len pulse, busy stays 0.
  - start with len=2049 → same.
- Start while busy and reset abort:
  - Start again with len=5 mid-frame of len=16 → frame completes with 16 sets.
  - Assert rst_n=1 at set 7 → all outputs 0 the next cycle, no done.
- Latency parameter: ROM_LAT=3, len=3 → tw_valid rises 3 cycles after the first rom_valid; done arrives 1 cycle after tw_last.

Source files
------------

// File: rtl/twiddle_addr_seq.sv
// Address/strobe sequencer feeding the 4-ROM twiddle reader: issues mirrored
// address pairs per frame and a latency-matched valid/last strobe for the butterfly.
module twiddle_addr_seq #(
    parameter int ADDR_W  = 11,
    parameter int ROM_LAT = 1,
    parameter int MAX_LEN = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              ready_i,
    output logic              rom_valid_o,
    output logic [ADDR_W-1:0] addr_col1_o,
    output logic [ADDR_W-1:0] addr_col2_o,
    output logic              tw_valid_o,
    output logic              tw_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_len_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX  = (ADDR_W+1)'(MAX_LEN);
    localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] LEN_ZERO = {(ADDR_W+1){1'b0}};

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     k_q, k_d;
    logic                rom_valid_q, rom_valid_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   addr1_q, addr1_d;
    logic [ADDR_W-1:0]   addr2_q, addr2_d;
    logic [ROM_LAT-1:0]  vpipe_q, vpipe_d;
    logic [ROM_LAT-1:0]  lpipe_q, lpipe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                len_ok_s;
    logic                is_last_s;
    logic [ADDR_W:0]     mirror_s;

    // k never exceeds len-1 while issuing, so the mirror never underflows
    assign len_ok_s  = (len_i != LEN_ZERO) && (len_i <= LEN_MAX);
    assign is_last_s = (k_q == (len_q - LEN_ONE));
    assign mirror_s  = len_q - LEN_ONE - k_q;

    // Frame FSM: next state, issue datapath and status flags
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        k_d         = k_q;
        rom_valid_d = 1'b0;
        last_d      = 1'b0;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_ok_s) begin
                        len_d   = len_i;
                        k_d     = LEN_ZERO;
                        state_d = S_RUN;
                    end else begin
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (ready_i) begin
                    rom_valid_d = 1'b1;
                    addr1_d     = k_q[ADDR_W-1:0];
                    addr2_d     = mirror_s[ADDR_W-1:0];
                    last_d      = is_last_s;
                    k_d         = k_q + LEN_ONE;
                    if (is_last_s) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                // the last flag reaching the pipe output means the final set is on the bus
                if (lpipe_q[ROM_LAT-1]) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // Latency-matching shift pipes for the valid and last strobes
    always_comb begin
        vpipe_d    = vpipe_q;
        lpipe_d    = lpipe_q;
        vpipe_d[0] = rom_valid_q;
        lpipe_d[0] = last_q;
        for (int i = 1; i < ROM_LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
            lpipe_d[i] = lpipe_q[i-1];
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= LEN_ZERO;
            k_q         <= LEN_ZERO;
            rom_valid_q <= 1'b0;
            last_q      <= 1'b0;
            addr1_q     <= {ADDR_W{1'b0}};
            addr2_q     <= {ADDR_W{1'b0}};
            vpipe_q     <= {ROM_LAT{1'b0}};
            lpipe_q     <= {ROM_LAT{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            k_q         <= k_d;
            rom_valid_q <= rom_valid_d;
            last_q      <= last_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            vpipe_q     <= vpipe_d;
            lpipe_q     <= lpipe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign rom_valid_o = rom_valid_q;
    assign addr_col1_o = addr1_q;
    assign addr_col2_o = addr2_q;
    assign tw_valid_o  = vpipe_q[ROM_LAT-1];
    assign tw_last_o   = lpipe_q[ROM_LAT-1];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_len_o   = err_q;

endmodule

// File: tb/tb_twiddle_addr_seq.sv
// Bench for twiddle_addr_seq: two instances (ROM_LAT 1 and 3) on shared stimulus,
// each checked every cycle against a timestamp-based frame model.
module tb_twiddle_addr_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] len = 12'd0;
    logic        ready = 1'b1;

    logic        d0_rv, d0_twv, d0_twl, d0_busy, d0_done, d0_err;
    logic [10:0] d0_a1, d0_a2;
    logic        d1_rv, d1_twv, d1_twl, d1_busy, d1_done, d1_err;
    logic [10:0] d1_a1, d1_a2;

    twiddle_addr_seq #(.ADDR_W(11), .ROM_LAT(1), .MAX_LEN(2048)) dut0 (
        .clk(clk), .rst_n(rst), .start_i(start), .len_i(len), .ready_i(ready),
        .rom_valid_o(d0_rv), .addr_col1_o(d0_a1), .addr_col2_o(d0_a2),
        .tw_valid_o(d0_twv), .tw_last_o(d0_twl), .busy_o(d0_busy),
        .done_o(d0_done), .err_len_o(d0_err)
    );

    twiddle_addr_seq #(.ADDR_W(11), .ROM_LAT(3), .MAX_LEN(2048)) dut1 (
        .clk(clk), .rst_n(rst), .start_i(start), .len_i(len), .ready_i(ready),
        .rom_valid_o(d1_rv), .addr_col1_o(d1_a1), .addr_col2_o(d1_a2),
        .tw_valid_o(d1_twv), .tw_last_o(d1_twl), .busy_o(d1_busy),
        .done_o(d1_done), .err_len_o(d1_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit m_ok = 1'b0;

    // model state per instance
    bit          m_iss[2];
    int          m_len[2], m_k[2], m_done_at[2];
    bit [7:0]    sv[2], sl[2];
    bit          e_rv[2], e_twv[2], e_twl[2], e_busy[2], e_done[2], e_err[2];
    logic [10:0] e_a1[2], e_a2[2];

    // capture of observed DUT activity
    int rv_cnt[2], tw_cnt[2], done_cnt[2], err_cnt[2];
    int first_rv[2], first_tw[2], last_cyc[2], done_cyc[2];
    int a1_q[$], a2_q[$];

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [27:0] act(input int i);
        if (i == 0) return {d0_rv, d0_a1, d0_a2, d0_twv, d0_twl, d0_busy, d0_done, d0_err};
        return {d1_rv, d1_a1, d1_a2, d1_twv, d1_twl, d1_busy, d1_done, d1_err};
    endfunction

    task automatic model_update();
        int slot;
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_iss[i] = 1'b0; m_done_at[i] = -100; sv[i] = 8'd0; sl[i] = 8'd0;
                e_rv[i] = 1'b0; e_twv[i] = 1'b0; e_twl[i] = 1'b0; e_busy[i] = 1'b0;
                e_done[i] = 1'b0; e_err[i] = 1'b0; e_a1[i] = 11'd0; e_a2[i] = 11'd0;
                m_ok = 1'b1;
            end else begin
                slot = cyc % 8;
                e_twv[i] = sv[i][slot]; e_twl[i] = sl[i][slot];
                sv[i][slot] = 1'b0; sl[i][slot] = 1'b0;
                e_rv[i] = 1'b0; e_err[i] = 1'b0;
                if (m_iss[i]) begin
                    if (ready) begin
                        e_rv[i] = 1'b1;
                        e_a1[i] = 11'(m_k[i]);
                        e_a2[i] = 11'(m_len[i] - 1 - m_k[i]);
                        slot = (cyc + lat(i)) % 8;
                        sv[i][slot] = 1'b1;
                        sl[i][slot] = (m_k[i] == m_len[i] - 1);
                        if (m_k[i] == m_len[i] - 1) begin
                            m_iss[i] = 1'b0;
                            m_done_at[i] = cyc + lat(i) + 1;
                        end
                        m_k[i] = m_k[i] + 1;
                    end
                end else if (start && cyc >= m_done_at[i] + 2) begin
                    if (len >= 12'd1 && len <= 12'd2048) begin
                        m_iss[i] = 1'b1; m_len[i] = int'(len); m_k[i] = 0;
                    end else begin
                        e_err[i] = 1'b1;
                    end
                end
                e_done[i] = (cyc == m_done_at[i]);
                e_busy[i] = m_iss[i] || (cyc < m_done_at[i]);
            end
        end
    endtask

    task automatic compare_and_capture();
        logic [27:0] a, e;
        for (int i = 0; i < 2; i++) begin
            a = act(i);
            e = {e_rv[i], e_a1[i], e_a2[i], e_twv[i], e_twl[i], e_busy[i], e_done[i], e_err[i]};
            if (m_ok) begin
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs lat=%0d cyc=%0d got=%h want=%h", lat(i), cyc, a, e);
                end
            end
            if (a[27] === 1'b1) begin
                rv_cnt[i]++;
                if (first_rv[i] < 0) first_rv[i] = cyc;
                if (i == 0) begin a1_q.push_back(int'(a[26:16])); a2_q.push_back(int'(a[15:5])); end
            end
            if (a[4] === 1'b1) begin
                tw_cnt[i]++;
                if (first_tw[i] < 0) first_tw[i] = cyc;
            end
            if (a[3] === 1'b1) last_cyc[i] = cyc;
            if (a[1] === 1'b1) begin done_cnt[i]++; done_cyc[i] = cyc; end
            if (a[0] === 1'b1) err_cnt[i]++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_and_capture();
    endtask

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            rv_cnt[i] = 0; tw_cnt[i] = 0; done_cnt[i] = 0; err_cnt[i] = 0;
            first_rv[i] = -1; first_tw[i] = -1; last_cyc[i] = -1; done_cyc[i] = -1;
        end
        a1_q.delete(); a2_q.delete();
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic wait_quiet(input int budget);
        int q = 0;
        bit ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            tick();
            if (!d0_busy && !d1_busy && !d0_done && !d1_done) q++;
            else q = 0;
            if (q >= 3) ok = 1'b1;
        end
        chk("quiet_timeout", int'(ok), 1);
    endtask

    task automatic go(input int l);
        start = 1'b1; len = 12'(l);
        tick();
        start = 1'b0;
    endtask

    int s_cyc;
    bit hit;

    initial begin
        clr();
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", int'(d0_busy), 0);

        // basic frame len=4
        clr(); go(4); s_cyc = cyc; wait_quiet(100);
        chk("t1_nsets", a1_q.size(), 4);
        for (int j = 0; j < 4 && j < a1_q.size(); j++) begin
            chk("t1_col1", a1_q[j], j);
            chk("t1_col2", a2_q[j], 3 - j);
        end
        chk("t1_first_issue", first_rv[0], s_cyc + 1);
        chk("t1_tw_lag", first_tw[0] - first_rv[0], 1);
        chk("t1_tw_cnt", tw_cnt[0], 4);
        chk("t1_last_pos", last_cyc[0], first_tw[0] + 3);
        chk("t1_done_lag", done_cyc[0] - last_cyc[0], 1);

        // stall after the second issue
        clr(); go(8); tick(); tick();
        ready = 1'b0;
        tick();
        chk("t2_rv_low", int'(d0_rv), 0);
        chk("t2_hold_c1", int'(d0_a1), 1);
        chk("t2_hold_c2", int'(d0_a2), 6);
        tick(); tick();
        ready = 1'b1;
        wait_quiet(100);
        chk("t2_tw_cnt", tw_cnt[0], 8);
        chk("t2_nsets", a1_q.size(), 8);
        for (int j = 0; j < 8 && j < a1_q.size(); j++) chk("t2_col1", a1_q[j], j);

        // len=1
        clr(); go(1); wait_quiet(100);
        chk("t3_nsets", a1_q.size(), 1);
        if (a1_q.size() > 0) begin
            chk("t3_col1", a1_q[0], 0);
            chk("t3_col2", a2_q[0], 0);
        end
        chk("t3_last_with_valid", last_cyc[0], first_tw[0]);

        // len=2048 full range
        clr(); go(2048); wait_quiet(2200);
        chk("t4_nsets", a1_q.size(), 2048);
        if (a1_q.size() > 0) begin
            chk("t4_last_c1", a1_q[a1_q.size()-1], 2047);
            chk("t4_last_c2", a2_q[a2_q.size()-1], 0);
        end
        chk("t4_no_err", err_cnt[0], 0);

        // illegal lengths
        clr(); go(0); tick(); tick(); go(2049); tick(); tick();
        chk("t5_err0", err_cnt[0], 2);
        chk("t5_err1", err_cnt[1], 2);
        chk("t5_no_issue", rv_cnt[0], 0);

        // start while busy is ignored
        clr(); go(16); tick(); tick(); tick(); tick(); go(5); wait_quiet(100);
        chk("t6_tw_cnt", tw_cnt[0], 16);
        if (a2_q.size() > 0) chk("t6_col2_first", a2_q[0], 15);

        // reset abort at set 7
        clr(); go(16);
        hit = 1'b0;
        for (int n = 0; n < 40 && !hit; n++) begin
            tick();
            if (tw_cnt[0] == 7) hit = 1'b1;
        end
        chk("t7_reach_set7", int'(hit), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t7_zero0", int'(act(0)), 0);
        chk("t7_zero1", int'(act(1)), 0);
        for (int n = 0; n < 20; n++) tick();
        chk("t7_no_done0", done_cnt[0], 0);
        chk("t7_no_done1", done_cnt[1], 0);

        // ROM_LAT=3 latency, len=3
        clr(); go(3); wait_quiet(100);
        chk("t8_lat3_lag", first_tw[1] - first_rv[1], 3);
        chk("t8_lat3_done", done_cyc[1] - last_cyc[1], 1);
        chk("t8_lat3_cnt", tw_cnt[1], 3);

        // ready toggling every cycle
        clr(); go(6);
        for (int n = 0; n < 20; n++) begin ready = ~ready; tick(); end
        ready = 1'b1; wait_quiet(100);
        chk("t9_nsets", a1_q.size(), 6);
        for (int j = 0; j < 6 && j < a1_q.size(); j++) chk("t9_col1", a1_q[j], j);

        // start coinciding with done is ignored
        clr(); go(2);
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            tick();
            if (d0_done) hit = 1'b1;
        end
        chk("t10_done_seen", int'(hit), 1);
        start = 1'b1; len = 12'd3; tick(); start = 1'b0;
        wait_quiet(100);
        chk("t10_ignored", rv_cnt[0], 2);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int r;
            rst   = ($urandom % 700 == 0);
            start = ($urandom % 6 == 0);
            r = int'($urandom % 16);
            if (r == 0)      len = 12'd0;
            else if (r == 1) len = 12'd2049;
            else if (r == 2) len = 12'd1;
            else             len = 12'(1 + $urandom % 40);
            ready = ($urandom % 4 != 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; ready = 1'b1;
        wait_quiet(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
